// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: datapath widths and the
// fixed 3-bit ALU operation encoding understood by the external ALU.
package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the ALU arbiter.
//   req_valid/req_ready : per-requester op handshake (ready is one-hot or 0)
//   req_a/req_b/req_ctrl: packed operands/op, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : one-hot held response and per-requester consume
//   rsp_result/rsp_zero/rsp_id : registered result, zero flag and owner index
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_id
    );
endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Round-robin arbiter: picks the first asserted request at or after the
// priority pointer (wrapping), and moves the pointer just past the winner
// whenever the winner is actually accepted.
//   clk, rst_n  : clock, async active-low reset (pointer -> 0)
//   req         : request vector
//   advance     : the current grant was accepted this cycle
//   grant       : one-hot grant (0 when no request)
//   grant_id    : index of the granted requester
//   grant_valid : some requester is granted
module alu_share_arbiter_rr #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [ID_W-1:0] ptr_r;

    // Scan from the pointer, wrapping, and keep the first hit only.
    always_comb begin
        grant       = {NUM_REQ{1'b0}};
        grant_id    = {ID_W{1'b0}};
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            automatic int   idx = (int'(ptr_r) + k) % NUM_REQ;
            automatic logic hit = req[idx] & ~grant_valid;
            grant[idx]  = hit;
            grant_id    = hit ? ID_W'(idx) : grant_id;
            grant_valid = grant_valid | hit;
        end
    end

    // Priority pointer: one past the last accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {ID_W{1'b0}};
        end else if (advance) begin
            ptr_r <= (grant_id == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// Round-robin grant, operand mux onto the ALU ports, and a single registered
// response slot (result, zero flag, owner) with valid/ready drain.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop the held response and block grants this cycle
//   bus        : requester/response bundle (slave side)
//   alu_a/alu_b/alu_ctrl : operands and op to the ALU (ADD 0+0 when idle)
//   alu_result/alu_zero  : ALU outputs, captured on accept
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    alu_share_arbiter_if.slave   bus,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [CTRL_W-1:0]    alu_ctrl,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zero
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [ID_W-1:0]    grant_id_s;
    logic               grant_found_s;
    logic               slot_free_s;
    logic               issue_ok_s;
    logic               accept_s;
    logic               drain_s;

    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [DATA_W-1:0]  rsp_result_r;
    logic               rsp_zero_r;
    logic [ID_W-1:0]    rsp_id_r;

    alu_share_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (bus.req_valid),
        .advance     (accept_s),
        .grant       (grant_s),
        .grant_id    (grant_id_s),
        .grant_valid (grant_found_s)
    );

    // Slot can take a new op when empty or when its owner consumes it this
    // cycle; a non-owner's rsp_ready is masked by rsp_valid_r.
    always_comb begin
        drain_s     = |(rsp_valid_r & bus.rsp_ready);
        slot_free_s = ~(|rsp_valid_r) | drain_s;
        issue_ok_s  = slot_free_s & ~flush & rst_n;
        ready_s     = issue_ok_s ? grant_s : {NUM_REQ{1'b0}};
        accept_s    = |(ready_s & bus.req_valid);
    end

    // Route the granted requester's fields to the ALU; idle drives ADD 0+0.
    always_comb begin
        alu_a    = {DATA_W{1'b0}};
        alu_b    = {DATA_W{1'b0}};
        alu_ctrl = ALU_ADD;
        if (issue_ok_s && grant_found_s) begin
            alu_a    = bus.req_a[int'(grant_id_s)*DATA_W +: DATA_W];
            alu_b    = bus.req_b[int'(grant_id_s)*DATA_W +: DATA_W];
            alu_ctrl = bus.req_ctrl[int'(grant_id_s)*CTRL_W +: CTRL_W];
        end else begin
            alu_ctrl = ALU_ADD;
        end
    end

    // Response slot: flush wins, a new accept overwrites (even while the old
    // one drains, so no bubble), a plain drain clears valid but keeps data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r  <= {NUM_REQ{1'b0}};
            rsp_result_r <= {DATA_W{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_id_r     <= {ID_W{1'b0}};
        end else if (flush) begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
        end else if (accept_s) begin
            rsp_valid_r  <= ready_s;
            rsp_result_r <= alu_result;
            rsp_zero_r   <= alu_zero;
            rsp_id_r     <= grant_id_s;
        end else if (drain_s) begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_id     = rsp_id_r;

endmodule
